bitwise_gate_pipe: RTL

BITWISE_GATE_PIPE -- requirements
Module: bitwise_gate_pipe

---
 rtl/bitwise_gate_pkg.sv | 14 +
 rtl/bitwise_gate_skid.sv | 47 ++++
 rtl/bitwise_gate_pipe.sv | 57 +++++
 3 files changed

// File: rtl/bitwise_gate_pkg.sv
// bitwise_gate_pkg: op codes and operand-count limits shared by the gate pipe.
package bitwise_gate_pkg;
  localparam int OP_W = 3;
  localparam int NIN_MIN = 2;
  localparam int NIN_MAX = 8;
  typedef enum logic [OP_W-1:0] {
    OP_NOR,
    OP_OR,
    OP_AND,
    OP_NAND,
    OP_XOR,
    OP_XNOR
  } op_e;
endpackage

// File: rtl/bitwise_gate_skid.sv
// bitwise_gate_skid: output register plus one-entry skid buffer; in_ready is registered.
module bitwise_gate_skid #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         out_valid_q, out_valid_d, skid_full_q, skid_full_d, in_ready_q, in_ready_d;
  logic [W-1:0] out_data_q, out_data_d, skid_q, skid_d;
  logic         acc, pop, load_out, to_skid;
  always_comb begin
    acc         = in_valid & in_ready_q;
    pop         = out_valid_q & out_ready;
    load_out    = ~out_valid_q | pop;
    to_skid     = ~skid_full_q & acc & out_valid_q & ~out_ready;
    out_valid_d = load_out ? (skid_full_q | acc) : out_valid_q;
    out_data_d  = load_out ? (skid_full_q ? skid_q : (acc ? in_data : out_data_q)) : out_data_q;
    skid_full_d = skid_full_q ? ~pop : to_skid;
    skid_d      = to_skid ? in_data : skid_q;
    in_ready_d  = ~skid_full_d;
  end
  // in_ready resets low and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: rtl/bitwise_gate_pipe.sv
// bitwise_gate_pipe: reduces NIN operands bit by bit with a selectable gate, one-cycle latency.
module bitwise_gate_pipe
  import bitwise_gate_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int NIN   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]      in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err
);
  if (NIN < NIN_MIN || NIN > NIN_MAX) begin : g_nin_chk
    $error("bitwise_gate_pipe: NIN outside legal range");
  end
  logic [WIDTH-1:0] and_r, or_r, xor_r, res;
  logic             err;
  always_comb begin
    and_r = in_data[WIDTH-1:0];
    or_r  = in_data[WIDTH-1:0];
    xor_r = in_data[WIDTH-1:0];
    for (int k = 1; k < NIN; k++) begin
      and_r = and_r & in_data[k*WIDTH +: WIDTH];
      or_r  = or_r | in_data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ in_data[k*WIDTH +: WIDTH];
    end
    err = 1'b0;
    case (in_op)
      OP_NOR:  res = ~or_r;
      OP_OR:   res = or_r;
      OP_AND:  res = and_r;
      OP_NAND: res = ~and_r;
      OP_XOR:  res = xor_r;
      OP_XNOR: res = ~xor_r;
      default: begin
        res = '0;
        err = 1'b1;
      end
    endcase
  end
  bitwise_gate_skid #(.W(WIDTH + 1)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({err, res}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_err, out_data})
  );
endmodule
